// File: rtl/serial_cmd_frame_detector_if.sv
// Byte stream, fifo and decoder handshake bundle for the frame detector.
// slave = detector side, master = upstream/bench side.
interface serial_cmd_frame_detector_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cmd_processed;
  logic       fifo_push;
  logic [7:0] fifo_data;
  logic       fifo_clear;
  logic       cmd_ready;
  logic       frame_error;
  logic       overrun;
  logic [7:0] frames_ok;

  modport slave (
    input  rx_data, rx_valid, cmd_processed,
    output fifo_push, fifo_data, fifo_clear,
    output cmd_ready, frame_error, overrun, frames_ok
  );

  modport master (
    output rx_data, rx_valid, cmd_processed,
    input  fifo_push, fifo_data, fifo_clear,
    input  cmd_ready, frame_error, overrun, frames_ok
  );
endinterface

// File: rtl/serial_cmd_frame_detector.sv
// Frame tracker FF FF 00 LEN payload EE EE feeding the command fifo.
// Optional inter-byte timeout: SERIAL_FRAME_TIMEOUT_EN.
module serial_cmd_frame_detector #(
  parameter int unsigned MAX_PAYLOAD_BYTES = 8,
  parameter int unsigned CMD_READY_CYCLES  = 10,
  parameter int unsigned TIMEOUT_CYCLES    = 50000
) (
  input  logic clk,
  input  logic rst,
  serial_cmd_frame_detector_if.slave bus
);

  typedef enum logic [3:0] {
    S_SOF0, S_SOF1, S_SPACE, S_LEN, S_PAYLOAD,
    S_EOF0, S_EOF1, S_READY, S_WAIT_DONE
  } state_t;

  localparam logic [7:0] LP_MAX = 8'(MAX_PAYLOAD_BYTES);
  localparam int unsigned RW = $clog2(CMD_READY_CYCLES + 1);
  localparam logic [RW-1:0] LP_RDY = RW'(CMD_READY_CYCLES);

  state_t        r_state;
  logic [7:0]    r_len;
  logic [7:0]    r_cnt;
  logic [7:0]    r_data;
  logic [7:0]    r_frames;
  logic          r_push;
  logic          r_clear;
  logic          r_err;
  logic          r_ovr;
  logic          r_rdy;
  logic          r_cp_d;
  logic [RW-1:0] r_rdy_cnt;

  logic   w_ok;
  state_t w_next;
  logic   w_cp_rise;

`ifdef SERIAL_FRAME_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LP_TO = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] r_idle;
  logic          w_active;
  assign w_active = (r_state inside {S_SOF1, S_SPACE, S_LEN,
                                     S_PAYLOAD, S_EOF0, S_EOF1});
`endif

  assign w_cp_rise = bus.cmd_processed & ~r_cp_d;

  always_comb begin
    w_ok   = 1'b0;
    w_next = S_SOF0;
    unique case (r_state)
      S_SOF0: begin
        w_ok   = (bus.rx_data == 8'hFF);
        w_next = S_SOF1;
      end
      S_SOF1: begin
        w_ok   = (bus.rx_data == 8'hFF);
        w_next = S_SPACE;
      end
      S_SPACE: begin
        w_ok   = (bus.rx_data == 8'h00);
        w_next = S_LEN;
      end
      S_LEN: begin
        w_ok   = (bus.rx_data <= LP_MAX);
        w_next = (bus.rx_data == 8'h00) ? S_EOF0 : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        w_ok   = 1'b1;
        w_next = ((r_cnt + 8'd1) == r_len) ? S_EOF0 : S_PAYLOAD;
      end
      S_EOF0: begin
        w_ok   = (bus.rx_data == 8'hEE);
        w_next = S_EOF1;
      end
      S_EOF1: begin
        w_ok   = (bus.rx_data == 8'hEE);
        w_next = S_READY;
      end
      default: begin
        w_ok   = 1'b0;
        w_next = r_state;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_SOF0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_frames  <= '0;
      r_push    <= 1'b0;
      r_clear   <= 1'b0;
      r_err     <= 1'b0;
      r_ovr     <= 1'b0;
      r_rdy     <= 1'b0;
      r_cp_d    <= 1'b0;
      r_rdy_cnt <= '0;
`ifdef SERIAL_FRAME_TIMEOUT_EN
      r_idle    <= '0;
`endif
    end else begin
      r_push  <= 1'b0;
      r_clear <= 1'b0;
      r_err   <= 1'b0;
      r_ovr   <= 1'b0;
      r_cp_d  <= bus.cmd_processed;
      unique case (r_state)
        S_READY: begin
          r_ovr <= bus.rx_valid;
          if (r_rdy_cnt == LP_RDY) begin
            r_rdy   <= 1'b0;
            r_state <= S_WAIT_DONE;
          end else begin
            r_rdy     <= 1'b1;
            r_rdy_cnt <= r_rdy_cnt + RW'(1);
          end
        end
        S_WAIT_DONE: begin
          r_ovr <= bus.rx_valid;
          if (w_cp_rise) r_state <= S_SOF0;
        end
        default: begin
          if (bus.rx_valid && w_ok) begin
            r_push  <= 1'b1;
            r_data  <= bus.rx_data;
            r_state <= w_next;
            if (r_state == S_LEN) begin
              r_len <= bus.rx_data;
              r_cnt <= '0;
            end
            if (r_state == S_PAYLOAD) r_cnt <= r_cnt + 8'd1;
            if (r_state == S_EOF1) begin
              r_frames  <= r_frames + 8'd1;
              r_rdy_cnt <= '0;
            end
          end else if (bus.rx_valid) begin
            // SOF0 holds nothing in the fifo, so no purge there
            r_state <= S_SOF0;
            if (r_state != S_SOF0) begin
              r_clear <= 1'b1;
              r_err   <= 1'b1;
            end
          end
        end
      endcase
`ifdef SERIAL_FRAME_TIMEOUT_EN
      if (bus.rx_valid) begin
        r_idle <= TW'(1);
      end else if (!w_active) begin
        r_idle <= '0;
      end else if (r_idle >= LP_TO) begin
        r_idle  <= '0;
        r_state <= S_SOF0;
        r_clear <= 1'b1;
        r_err   <= 1'b1;
      end else begin
        r_idle <= r_idle + TW'(1);
      end
`endif
    end
  end

  assign bus.fifo_push   = r_push;
  assign bus.fifo_data   = r_data;
  assign bus.fifo_clear  = r_clear;
  assign bus.cmd_ready   = r_rdy;
  assign bus.frame_error = r_err;
  assign bus.overrun     = r_ovr;
  assign bus.frames_ok   = r_frames;

endmodule

// File: tb/tb_serial_cmd_frame_detector.sv
// Directed bench for serial_cmd_frame_detector.
// Build with +define+SERIAL_FRAME_TIMEOUT_EN to exercise the timeout.
module tb_serial_cmd_frame_detector;

  localparam int PER = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #(PER/2) clk = ~clk;

  serial_cmd_frame_detector_if bus();

  serial_cmd_frame_detector #(
    .MAX_PAYLOAD_BYTES(8),
    .CMD_READY_CYCLES (10),
    .TIMEOUT_CYCLES   (100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  int   n_push = 0, n_clr = 0, n_err = 0, n_ovr = 0, n_rdy = 0;
  time  t_push = 0, t_rdy = 0, t_err = 0, t_strobe = 0;
  logic rdy_q  = 1'b0;
  logic [7:0] pq[$];
  logic [7:0] exp_q[$];
  int   p0, c0, e0, o0, r0;

  always @(negedge clk) begin
    if (rst) begin
      if (bus.fifo_push) begin
        n_push++;
        pq.push_back(bus.fifo_data);
        t_push = $time;
      end
      if (bus.fifo_clear) n_clr++;
      if (bus.frame_error) begin
        n_err++;
        t_err = $time;
      end
      if (bus.overrun) n_ovr++;
      if (bus.cmd_ready) begin
        n_rdy++;
        if (!rdy_q) t_rdy = $time;
      end
      rdy_q = bus.cmd_ready;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic snap();
    p0 = n_push; c0 = n_clr; e0 = n_err; o0 = n_ovr; r0 = n_rdy;
    pq.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    t_strobe     = $time - 1;
    tick(1);
    bus.rx_valid = 1'b0;
    tick(7);
  endtask

  task automatic send_frame(input int len, input logic [7:0] start,
                            input logic [7:0] step);
    logic [7:0] v;
    v = start;
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'(len));
    for (int i = 0; i < len; i++) begin
      send_byte(v);
      v = v + step;
    end
    send_byte(8'hEE);
    send_byte(8'hEE);
  endtask

  task automatic build_exp(input int len, input logic [7:0] start,
                           input logic [7:0] step);
    logic [7:0] v;
    v = start;
    exp_q = {};
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(v);
      v = v + step;
    end
    exp_q.push_back(8'hEE);
    exp_q.push_back(8'hEE);
  endtask

  task automatic chk_q(input string tag);
    logic [7:0] got;
    chk({tag, "_count"}, pq.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < pq.size()) ? pq[i] : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, got}, {24'd0, exp_q[i]});
    end
  endtask

  task automatic ack();
    tick(6);
    bus.cmd_processed = 1'b1;
    tick(2);
    bus.cmd_processed = 1'b0;
    tick(2);
  endtask

  initial begin
    bus.rx_data       = 8'h00;
    bus.rx_valid      = 1'b0;
    bus.cmd_processed = 1'b0;
    rst               = 1'b0;
    tick(3);
    chk("rst_push",   bus.fifo_push,   0);
    chk("rst_clear",  bus.fifo_clear,  0);
    chk("rst_ready",  bus.cmd_ready,   0);
    chk("rst_error",  bus.frame_error, 0);
    chk("rst_ovr",    bus.overrun,     0);
    chk("rst_frames", bus.frames_ok,   0);
    rst = 1'b1;
    tick(2);

    // 1: good frame, 6-byte payload
    snap();
    send_frame(6, 8'h11, 8'h11);
    tick(4);
    build_exp(6, 8'h11, 8'h11);
    chk_q("t1");
    chk("t1_ready_cycles", n_rdy - r0, 10);
    chk("t1_ready_after_push", 32'(t_rdy - t_push), PER);
    chk("t1_frames", bus.frames_ok, 1);
    chk("t1_no_error", n_err - e0, 0);
    ack();

    // 2: bad SPACE byte, then good frame
    snap();
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'h01);
    chk("t2_push", n_push - p0, 2);
    chk("t2_error", n_err - e0, 1);
    chk("t2_clear", n_clr - c0, 1);
    chk("t2_error_lat", 32'(t_err - t_strobe), PER);
    chk("t2_no_ready", n_rdy - r0, 0);
    snap();
    send_frame(6, 8'h10, 8'h10);
    tick(4);
    build_exp(6, 8'h10, 8'h10);
    chk_q("t2b");
    chk("t2_frames", bus.frames_ok, 2);
    ack();

    // 3: LEN over the limit, SOF0 junk, LEN at the limit
    snap();
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'h09);
    tick(20);
    chk("t3_push", n_push - p0, 3);
    chk("t3_error", n_err - e0, 1);
    chk("t3_clear", n_clr - c0, 1);
    chk("t3_no_ready", n_rdy - r0, 0);
    chk("t3_frames", bus.frames_ok, 2);
    snap();
    send_byte(8'h12);
    chk("t3_sof_push", n_push - p0, 0);
    chk("t3_sof_error", n_err - e0, 0);
    chk("t3_sof_clear", n_clr - c0, 0);
    snap();
    send_frame(8, 8'h01, 8'h01);
    tick(4);
    chk("t3_max_push", n_push - p0, 14);
    chk("t3_max_ready", n_rdy - r0, 10);
    chk("t3_max_frames", bus.frames_ok, 3);
    ack();

    // 4: overruns while the decoder is busy
    send_frame(2, 8'hA1, 8'h01);
    snap();
    send_byte(8'h55);
    send_byte(8'h56);
    send_byte(8'h57);
    chk("t4_ovr", n_ovr - o0, 3);
    chk("t4_ovr_push", n_push - p0, 0);
    bus.cmd_processed = 1'b1;
    bus.rx_data       = 8'hFF;
    bus.rx_valid      = 1'b1;
    tick(1);
    bus.rx_valid = 1'b0;
    tick(3);
    chk("t4_edge_ovr", n_ovr - o0, 4);
    chk("t4_edge_push", n_push - p0, 0);
    snap();
    send_frame(1, 8'h77, 8'h00);
    tick(10);
    chk("t4_held_push", n_push - p0, 7);
    chk("t4_held_ready", n_rdy - r0, 10);
    chk("t4_held_frames", bus.frames_ok, 5);
    send_byte(8'hFF);
    chk("t4_held_ovr", n_ovr - o0, 1);
    chk("t4_held_nopush", n_push - p0, 7);
    bus.cmd_processed = 1'b0;
    tick(2);
    bus.cmd_processed = 1'b1;
    tick(2);
    bus.cmd_processed = 1'b0;
    tick(2);
    snap();
    send_frame(0, 8'h00, 8'h00);
    tick(4);
    chk("t4_after_push", n_push - p0, 6);
    chk("t4_after_frames", bus.frames_ok, 6);
    ack();

    // reset in the middle of a frame
    send_byte(8'hFF);
    send_byte(8'hFF);
    rst = 1'b0;
    tick(1);
    chk("mid_rst_frames", bus.frames_ok, 0);
    chk("mid_rst_push", bus.fifo_push, 0);
    rst = 1'b1;
    tick(2);
    snap();
    send_frame(0, 8'h00, 8'h00);
    tick(4);
    chk("mid_rst_push_n", n_push - p0, 6);
    chk("mid_rst_err", n_err - e0, 0);
    chk("mid_rst_frames1", bus.frames_ok, 1);
    ack();

    // 5: empty frames until the counter wraps
    snap();
    repeat (254) begin
      send_frame(0, 8'h00, 8'h00);
      ack();
    end
    chk("t5_frames_255", bus.frames_ok, 255);
    send_frame(0, 8'h00, 8'h00);
    tick(4);
    chk("t5_frames_wrap", bus.frames_ok, 0);
    ack();
    chk("t5_push", n_push - p0, 255 * 6);
    chk("t5_ready", n_rdy - r0, 255 * 10);
    chk("t5_error", n_err - e0, 0);

    // 6: stalled partial frame
    snap();
    send_byte(8'hFF);
    send_byte(8'hFF);
    send_byte(8'h00);
`ifdef SERIAL_FRAME_TIMEOUT_EN
    tick(110);
    chk("t6_error", n_err - e0, 1);
    chk("t6_clear", n_clr - c0, 1);
    chk("t6_latency", 32'(t_err - t_strobe), 100 * PER);
`else
    tick(1000);
    chk("t6_no_error", n_err - e0, 0);
    chk("t6_no_clear", n_clr - c0, 0);
`endif
    chk("t6_push", n_push - p0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
